// File: rtl/airlock_pkg.sv
// Shared definitions for the airlock interlock sequencer.
// Contents: state width, the state encodings, and the default dwell time.
package airlock_pkg;

  localparam int unsigned STATE_W              = 4;
  localparam int unsigned DEFAULT_DWELL_CYCLES = 5;

  // These encodings are visible on the debug state output, so they are fixed.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE_P      = 4'd0,
    ST_DEPRESS     = 4'd1,
    ST_OPEN_OUTER  = 4'd2,
    ST_CLOSE_OUTER = 4'd3,
    ST_IDLE_V      = 4'd4,
    ST_PRESS       = 4'd5,
    ST_OPEN_INNER  = 4'd6,
    ST_CLOSE_INNER = 4'd7,
    ST_FAULT       = 4'd8
  } state_t;

endpackage

// File: rtl/airlock_sequencer_if.sv
// Panel/sensor/actuator bundle for the airlock sequencer.
//   master : drives requests, door sensors and fault_clr; observes commands.
//   slave  : the sequencer side.
interface airlock_sequencer_if;

  logic                             req_inner;
  logic                             req_outer;
  logic                             inner_closed;
  logic                             outer_closed;
  logic                             fault_clr;
  logic                             inner_open_cmd;
  logic                             outer_open_cmd;
  logic                             pump_on;
  logic                             vent_on;
  logic                             fault;
  logic [airlock_pkg::STATE_W-1:0]  state;

  modport master (
    output req_inner, req_outer, inner_closed, outer_closed, fault_clr,
    input  inner_open_cmd, outer_open_cmd, pump_on, vent_on, fault, state
  );

  modport slave (
    input  req_inner, req_outer, inner_closed, outer_closed, fault_clr,
    output inner_open_cmd, outer_open_cmd, pump_on, vent_on, fault, state
  );

endinterface

// File: rtl/at_state_dwell_counter.sv
// Cycles-in-current-state counter.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   clr   : synchronous clear (asserted on the edge that changes state)
//   count : cycles since entering the state, saturating at all-ones
module at_state_dwell_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/airlock_sequencer.sv
// Two-door airlock interlock controller (Moore).
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : requests, door-closed sensors, fault_clr in; door/pump/vent
//         commands, fault flag and debug state out
// Timed states (DEPRESS, PRESS, OPEN_OUTER, OPEN_INNER) last DWELL_CYCLES.
module airlock_sequencer
  import airlock_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                clk,
  input  logic                rst,
  airlock_sequencer_if.slave  bus
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] dwell_count;
  logic             dwell_done;
  logic             inner_may_open;
  logic             outer_may_open;
  logic             door_fault;

  at_state_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_d != state_q),
    .count (dwell_count)
  );

  assign dwell_done = (dwell_count == CNT_W'(DWELL_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE_P;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    inner_may_open = (state_q == ST_OPEN_INNER) || (state_q == ST_CLOSE_INNER);
    outer_may_open = (state_q == ST_OPEN_OUTER) || (state_q == ST_CLOSE_OUTER);
    door_fault     = (!bus.inner_closed && !inner_may_open) ||
                     (!bus.outer_closed && !outer_may_open);

    if (state_q != ST_FAULT && door_fault) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE_P: begin
          if (bus.req_inner)      state_d = ST_OPEN_INNER;
          else if (bus.req_outer) state_d = ST_DEPRESS;
        end
        ST_IDLE_V: begin
          if (bus.req_outer)      state_d = ST_OPEN_OUTER;
          else if (bus.req_inner) state_d = ST_PRESS;
        end
        ST_DEPRESS:     if (dwell_done) state_d = ST_OPEN_OUTER;
        ST_PRESS:       if (dwell_done) state_d = ST_OPEN_INNER;
        ST_OPEN_OUTER:  if (dwell_done) state_d = ST_CLOSE_OUTER;
        ST_OPEN_INNER:  if (dwell_done) state_d = ST_CLOSE_INNER;
        ST_CLOSE_OUTER: if (bus.outer_closed) state_d = ST_IDLE_V;
        ST_CLOSE_INNER: if (bus.inner_closed) state_d = ST_IDLE_P;
        // Pressure is unknown after a fault, so recovery always re-pressurises.
        ST_FAULT: begin
          if (bus.fault_clr && bus.inner_closed && bus.outer_closed)
            state_d = ST_PRESS;
        end
        default: state_d = ST_FAULT;
      endcase
    end
  end

  assign bus.vent_on        = (state_q == ST_DEPRESS);
  assign bus.pump_on        = (state_q == ST_PRESS);
  assign bus.outer_open_cmd = (state_q == ST_OPEN_OUTER);
  assign bus.inner_open_cmd = (state_q == ST_OPEN_INNER);
  assign bus.fault          = (state_q == ST_FAULT);
  assign bus.state          = state_q;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Bench for airlock_sequencer: three instances (dwell 5, 1, 8) share one
// stimulus stream; each is compared against a route-plan reference model.
module tb_airlock_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ri = 1'b0, ro = 1'b0, ic = 1'b1, oc = 1'b1, fc = 1'b0;

  always #5 clk = ~clk;

  airlock_sequencer_if bus5();
  airlock_sequencer_if bus1();
  airlock_sequencer_if bus8();

  assign bus5.req_inner = ri;  assign bus5.req_outer = ro;
  assign bus5.inner_closed = ic; assign bus5.outer_closed = oc;
  assign bus5.fault_clr = fc;
  assign bus1.req_inner = ri;  assign bus1.req_outer = ro;
  assign bus1.inner_closed = ic; assign bus1.outer_closed = oc;
  assign bus1.fault_clr = fc;
  assign bus8.req_inner = ri;  assign bus8.req_outer = ro;
  assign bus8.inner_closed = ic; assign bus8.outer_closed = oc;
  assign bus8.fault_clr = fc;

  airlock_sequencer #(.DWELL_CYCLES(5), .CNT_W(3)) u_d5 (.clk(clk), .rst(rst), .bus(bus5.slave));
  airlock_sequencer #(.DWELL_CYCLES(1), .CNT_W(3)) u_d1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  airlock_sequencer #(.DWELL_CYCLES(8), .CNT_W(3)) u_d8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  // Observed outputs: {inner_open, outer_open, pump, vent, fault}
  logic [3:0] dst  [3];
  logic [4:0] dout [3];
  assign dst[0]  = bus5.state;
  assign dst[1]  = bus1.state;
  assign dst[2]  = bus8.state;
  assign dout[0] = {bus5.inner_open_cmd, bus5.outer_open_cmd, bus5.pump_on, bus5.vent_on, bus5.fault};
  assign dout[1] = {bus1.inner_open_cmd, bus1.outer_open_cmd, bus1.pump_on, bus1.vent_on, bus1.fault};
  assign dout[2] = {bus8.inner_open_cmd, bus8.outer_open_cmd, bus8.pump_on, bus8.vent_on, bus8.fault};

  int dw [3] = '{5, 1, 8};

  // Reference model: current state plus a precomputed list of the states a
  // started sequence will walk through, one entry per cycle.
  int mst   [3];
  int plan  [3][0:23];
  int plen  [3];
  int phead [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       ri, ro, ic, oc, fc;
    logic [3:0] st;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [4:0] dec(int st);
    return {st == 6, st == 2, st == 5, st == 1, st == 8};
  endfunction

  task automatic chk(string name, int i, logic [8:0] act, logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dwell=%0d: got state/outs %h, expected %h at %0t", name, dw[i], act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mst[i] = 0; plen[i] = 0; phead[i] = 0;
    end
  endtask

  task automatic route(int i, int a, int b, int c);
    plen[i] = 0; phead[i] = 0;
    for (int k = 0; k < dw[i]; k++) begin plan[i][plen[i]] = a; plen[i]++; end
    if (b >= 0)
      for (int k = 0; k < dw[i]; k++) begin plan[i][plen[i]] = b; plen[i]++; end
    plan[i][plen[i]] = c; plen[i]++;
    mst[i] = plan[i][0];
    phead[i] = 1;
  endtask

  task automatic model_step(int i);
    int  cur;
    bit  viol;
    cur  = mst[i];
    viol = (cur != 8) && ((!ic && !(cur == 6 || cur == 7)) || (!oc && !(cur == 2 || cur == 3)));
    if (!rst) begin
      mst[i] = 0; plen[i] = 0; phead[i] = 0;
    end else if (viol) begin
      mst[i] = 8; plen[i] = 0; phead[i] = 0;
    end else if (phead[i] < plen[i]) begin
      mst[i] = plan[i][phead[i]];
      phead[i]++;
    end else begin
      case (cur)
        0: if (ri) route(i, 6, -1, 7); else if (ro) route(i, 1, 2, 3);
        4: if (ro) route(i, 2, -1, 3); else if (ri) route(i, 5, 6, 7);
        3: if (oc) mst[i] = 4;
        7: if (ic) mst[i] = 0;
        8: if (fc && ic && oc) route(i, 5, 6, 7);
        default: ;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("model", i, {dst[i], dout[i]}, {4'(mst[i]), dec(mst[i])});
      checks++;
      if ((dout[i][4] & dout[i][3]) | (dout[i][2] & dout[i][1]) |
          ((dout[i][4] | dout[i][3]) & (dout[i][2] | dout[i][1]))) begin
        errors++;
        $display("FAIL invariant dwell=%0d: outs %b, required no conflicting commands", dw[i], dout[i]);
      end
    end
  endtask

  task automatic reset_all();
    rst = 1'b0;
    #1 model_reset();
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic add(logic a, logic b, logic c, logic d, logic e, logic [3:0] s, int n);
    vec_t v;
    v.ri = a; v.ro = b; v.ic = c; v.oc = d; v.fc = e; v.st = s;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  int n1 [3];
  int n2 [3];
  int k;

  initial begin
    // Exit/entry sequences for the dwell-5 instance, one row per edge.
    add(0, 1, 1, 1, 0, 4'd1, 1);
    add(0, 0, 1, 1, 0, 4'd1, 4);
    add(0, 0, 1, 1, 0, 4'd2, 1);
    add(1, 0, 1, 1, 0, 4'd2, 1);   // request ignored mid-sequence
    add(0, 0, 1, 0, 0, 4'd2, 3);   // outer door physically opens
    add(0, 0, 1, 0, 0, 4'd3, 3);   // closing, still open: wait
    add(0, 0, 1, 1, 0, 4'd4, 1);
    add(0, 0, 1, 1, 0, 4'd4, 1);
    add(1, 1, 1, 1, 0, 4'd2, 1);   // both requests in IDLE_V: outer wins
    add(0, 0, 1, 1, 0, 4'd2, 4);
    add(0, 0, 1, 1, 0, 4'd3, 1);
    add(0, 0, 1, 1, 0, 4'd4, 1);
    add(1, 0, 1, 1, 0, 4'd5, 1);
    add(0, 0, 1, 1, 0, 4'd5, 4);
    add(0, 0, 1, 1, 0, 4'd6, 5);
    add(0, 0, 1, 1, 0, 4'd7, 1);
    add(0, 0, 1, 1, 0, 4'd0, 1);
    add(1, 1, 1, 1, 0, 4'd6, 1);   // both requests in IDLE_P: inner wins
    add(0, 0, 1, 1, 0, 4'd6, 4);
    add(0, 0, 1, 1, 0, 4'd7, 1);
    add(0, 0, 1, 1, 0, 4'd0, 1);

    // Reset then idle
    reset_all();
    for (int n = 0; n < 10; n++) begin
      step();
      for (int i = 0; i < 3; i++) chk("idle_after_reset", i, {dst[i], dout[i]}, 9'd0);
    end

    // Table-driven sequence
    for (int n = 0; n < tbl.size(); n++) begin
      ri = tbl[n].ri; ro = tbl[n].ro; ic = tbl[n].ic; oc = tbl[n].oc; fc = tbl[n].fc;
      step();
      chk("table", 0, {dst[0], dout[0]}, {tbl[n].st, dec(tbl[n].st)});
    end
    ri = 0; ro = 0; ic = 1; oc = 1; fc = 0;

    // Interlock fault during PRESS and recovery
    reset_all();
    ro = 1; step(); ro = 0;
    for (k = 0; k < 40 && dst[0] != 4'd4; k++) step();
    chk("reach_idle_v", 0, {dst[0], dout[0]}, {4'd4, 5'b00000});
    ri = 1; step(); ri = 0;
    chk("press_entry", 0, {dst[0], dout[0]}, {4'd5, 5'b00100});
    ic = 0; step();
    chk("fault_entry", 0, {dst[0], dout[0]}, {4'd8, 5'b00001});
    fc = 1; step();
    chk("fault_hold_open", 0, {dst[0], dout[0]}, {4'd8, 5'b00001});
    ic = 1; step(); fc = 0;
    chk("fault_clear", 0, {dst[0], dout[0]}, {4'd5, 5'b00100});

    // Asynchronous reset in cycle 3 of DEPRESS
    reset_all();
    ro = 1; step(); ro = 0;
    step(); step();
    chk("depress_c3", 0, {dst[0], dout[0]}, {4'd1, 5'b00010});
    #2 rst = 1'b0;
    #1 model_reset();
    chk("async_reset", 0, {dst[0], dout[0]}, 9'd0);
    step();
    rst = 1'b1;

    // Dwell boundaries: each timed state lasts exactly its dwell count
    reset_all();
    for (int i = 0; i < 3; i++) begin n1[i] = 0; n2[i] = 0; end
    ro = 1;
    for (int n = 0; n < 40; n++) begin
      step();
      ro = 0;
      for (int i = 0; i < 3; i++) begin
        if (dst[i] == 4'd1) n1[i]++;
        if (dst[i] == 4'd2) n2[i]++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk("depress_len", i, 9'(n1[i]), 9'(dw[i]));
      chk("open_outer_len", i, 9'(n2[i]), 9'(dw[i]));
      chk("end_idle_v", i, {dst[i], dout[i]}, {4'd4, 5'b00000});
    end

    // Randomized traffic against the model
    reset_all();
    for (int n = 0; n < 800; n++) begin
      ri  = ($urandom % 4) == 0;
      ro  = ($urandom % 4) == 0;
      ic  = ($urandom % 16) != 0;
      oc  = ($urandom % 16) != 0;
      fc  = ($urandom % 4) == 0;
      rst = ($urandom % 150) != 0;
      step();
    end
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
